// File: rtl/mic_i2s_rx.sv
`default_nettype none
// ============================================================================
// Module   : mic_i2s_rx
// Brief    : I2S receiver for a digital microphone. Synchronises the
//            asynchronous sck/ws/sd pins into the clk domain, captures the
//            left-channel word MSB first, and presents it on a valid/ready
//            output with sticky overrun and frame-error flags.
// Revision : 1.0 - initial release
// ============================================================================
module mic_i2s_rx #(
  parameter int SAMPLE_W    = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sck,
  input  logic                ws,
  input  logic                sd,
  output logic [SAMPLE_W-1:0] mic,
  output logic                mic_valid,
  input  logic                mic_ready,
  output logic                overrun,
  output logic                frame_err
);

  // bit_cnt must be able to hold SAMPLE_W itself (the "word complete" count)
  localparam int CNT_W = $clog2(SAMPLE_W + 1);
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(SAMPLE_W - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_WAIT    = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Pin synchronisers: bit 0 takes the raw pin, bit SYNC_STAGES-1 is the
  // value the rest of the block uses.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ws_sync_q,  ws_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q,  sd_sync_d;
  logic                   sck_prev_q, sck_prev_d;

  logic sck_s;
  logic ws_s;
  logic sd_s;
  logic sck_rise;

  // Shift each pin one stage further into the clk domain
  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
    ws_sync_d  = {ws_sync_q[SYNC_STAGES-2:0],  ws};
    sd_sync_d  = {sd_sync_q[SYNC_STAGES-2:0],  sd};
    sck_prev_d = sck_s;
  end

  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign ws_s  = ws_sync_q[SYNC_STAGES-1];
  assign sd_s  = sd_sync_q[SYNC_STAGES-1];

  // sck_prev resets to 0 alongside the synchronisers, so no rise can be seen
  // until a real 1 has travelled through the whole chain.
  assign sck_rise = sck_s & ~sck_prev_q;

  // Synchroniser and edge-detect registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q <= '0;
      ws_sync_q  <= '0;
      sd_sync_q  <= '0;
      sck_prev_q <= 1'b0;
    end else begin
      sck_sync_q <= sck_sync_d;
      ws_sync_q  <= ws_sync_d;
      sd_sync_q  <= sd_sync_d;
      sck_prev_q <= sck_prev_d;
    end
  end

  // --------------------------------------------------------------------------
  // Slot framing and word capture
  // --------------------------------------------------------------------------
  state_t                state_q,   state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0]   shift_q,   shift_d;
  logic                  ws_prev_q, ws_prev_d;
  // ws_seen marks that ws_prev came from a real rise rather than from reset.
  // Without it, a rise with ws=0 straight after reset would look like a
  // 1->0 transition and start capturing the middle of a slot.
  logic                  ws_seen_q, ws_seen_d;

  logic                  left_start;
  logic                  word_done;
  logic                  slot_short;
  logic [SAMPLE_W-1:0]   new_word;

  assign left_start = sck_rise & ~ws_s & ws_prev_q & ws_seen_q;
  assign new_word   = {shift_q[SAMPLE_W-2:0], sd_s};

  // Next-state logic: every decision is taken only on a detected sck rise
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ws_prev_d  = ws_prev_q;
    ws_seen_d  = ws_seen_q;
    word_done  = 1'b0;
    slot_short = 1'b0;

    if (sck_rise) begin
      ws_prev_d = ws_s;
      ws_seen_d = 1'b1;

      case (state_q)
        ST_IDLE, ST_WAIT: begin
          // The sd on this rise is the previous slot's LSB, so nothing is
          // shifted here; the left MSB arrives on the next rise.
          if (left_start) begin
            state_d   = ST_CAPTURE;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end

        ST_CAPTURE: begin
          if (!ws_s) begin
            shift_d   = new_word;
            bit_cnt_d = bit_cnt_q + C_CNT_ONE;
            if (bit_cnt_q == C_LAST_CNT) begin
              word_done = 1'b1;
              state_d   = ST_WAIT;
            end
          end else begin
            // Right slot started before the left word was complete
            slot_short = 1'b1;
            shift_d    = '0;
            bit_cnt_d  = '0;
            state_d    = ST_WAIT;
          end
        end

        default: begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      endcase
    end
  end

  // Capture state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ws_prev_q <= 1'b1;
      ws_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ws_prev_q <= ws_prev_d;
      ws_seen_q <= ws_seen_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output holding register with valid/ready handshake and sticky flags
  // --------------------------------------------------------------------------
  logic [SAMPLE_W-1:0] mic_q,       mic_d;
  logic                mic_valid_q, mic_valid_d;
  logic                overrun_q,   overrun_d;
  logic                frame_err_q, frame_err_d;

  // Load a finished word when the register is free or being emptied this
  // cycle; otherwise keep the held word untouched and flag the loss.
  always_comb begin
    mic_d       = mic_q;
    mic_valid_d = mic_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q | slot_short;

    if (word_done) begin
      if (!mic_valid_q || mic_ready) begin
        mic_d       = new_word;
        mic_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (mic_valid_q && mic_ready) begin
      mic_valid_d = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mic_q       <= '0;
      mic_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      mic_q       <= mic_d;
      mic_valid_q <= mic_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign mic       = mic_q;
  assign mic_valid = mic_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mic_i2s_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mic_i2s_rx
// Brief    : Directed I2S frames against mic_i2s_rx. A transaction-level
//            model turns "this sck rise delivers a full left word / ends a
//            short slot" into timed events and applies the handshake rules;
//            a per-cycle compare process checks the DUT against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mic_i2s_rx;

  localparam int SAMPLE_W    = 24;
  localparam int SYNC_STAGES = 2;
  localparam int SLOT_LEN    = 32;
  localparam int HALF        = 4;   // clk cycles per sck half period

  logic                clk = 1'b0;
  logic                rst;
  logic                sck;
  logic                ws;
  logic                sd;
  logic                mic_ready;
  logic [SAMPLE_W-1:0] mic;
  logic                mic_valid;
  logic                overrun;
  logic                frame_err;

  always #5 clk = ~clk;

  mic_i2s_rx #(
    .SAMPLE_W    (SAMPLE_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sck       (sck),
    .ws        (ws),
    .sd        (sd),
    .mic       (mic),
    .mic_valid (mic_valid),
    .mic_ready (mic_ready),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Timed events: a full left word lands, or a short slot is detected
  typedef struct {
    int                  due;
    bit                  is_word;
    logic [SAMPLE_W-1:0] word;
  } ev_t;
  ev_t evq[$];

  logic [SAMPLE_W-1:0] m_mic   = '0;
  bit                  m_valid = 1'b0;
  bit                  m_over  = 1'b0;
  bit                  m_ferr  = 1'b0;

  int                  valid_cnt = 0;
  logic [SAMPLE_W-1:0] last_valid_mic = '0;
  logic                last_sd = 1'b0;
  bit                  pulse_armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a completed word is loaded if the output is free or drained this
  // cycle, else it is lost and overrun is raised; a transfer empties it.
  initial forever begin
    bit                  done;
    logic [SAMPLE_W-1:0] w;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_mic   = '0;
      m_valid = 1'b0;
      m_over  = 1'b0;
      m_ferr  = 1'b0;
      evq.delete();
    end else begin
      done = 1'b0;
      w    = '0;
      foreach (evq[i]) begin
        if (evq[i].due == cyc) begin
          if (evq[i].is_word) begin
            done = 1'b1;
            w    = evq[i].word;
          end else begin
            m_ferr = 1'b1;
          end
        end
      end
      while (evq.size() > 0 && evq[0].due <= cyc) void'(evq.pop_front());
      if (done) begin
        if (!m_valid || mic_ready) begin
          m_mic   = w;
          m_valid = 1'b1;
        end else begin
          m_over = 1'b1;
        end
      end else if (m_valid && mic_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare every cycle, away from the active edge
  initial forever begin
    @(negedge clk);
    #1;
    if (rst === 1'b1) begin
      check("rst_mic",       32'(mic),  32'd0);
      check("rst_mic_valid", 32'(mic_valid), 32'd0);
      check("rst_overrun",   32'(overrun),   32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
    end else if (rst === 1'b0) begin
      check("mic_valid", 32'(mic_valid), 32'(m_valid));
      check("overrun",   32'(overrun),   32'(m_over));
      check("frame_err", 32'(frame_err), 32'(m_ferr));
      if (m_valid) check("mic", 32'(mic), 32'(m_mic));
      if (mic_valid === 1'b1) begin
        valid_cnt++;
        last_valid_mic = mic;
      end
    end
  end

  // One sck period. Called just after a negedge with sck low; ws/sd change
  // while sck is low and are held through the rise.
  task automatic send_bit(input logic wsv, input logic sdv, input bit is_lsb,
                          input logic [SAMPLE_W-1:0] word, input bit short_rise);
    int due;
    bit arm;
    ws = wsv;
    sd = sdv;
    repeat (HALF) @(negedge clk);
    sck = 1'b1;
    // Rise is seen after SYNC_STAGES clk edges; the result registers one later
    due = cyc + SYNC_STAGES + 1;
    arm = pulse_armed && is_lsb;
    if (is_lsb)     evq.push_back('{due: due, is_word: 1'b1, word: word});
    if (short_rise) evq.push_back('{due: due, is_word: 1'b0, word: '0});
    for (int k = 0; k < HALF; k++) begin
      @(negedge clk);
      if (arm && cyc == due - 1) mic_ready = 1'b1;
      if (arm && cyc == due) begin
        mic_ready   = 1'b0;
        pulse_armed = 1'b0;
      end
    end
    sck = 1'b0;
  endtask

  // One slot: rise 0 carries the previous slot's last bit, then nbits of
  // word MSB first (top bits when nbits < SAMPLE_W), then 1010.. padding.
  task automatic send_slot(input logic wsv, input logic [SAMPLE_W-1:0] word, input int nbits,
                           input int len, input bit full_left, input bit short_first);
    logic b;
    send_bit(wsv, last_sd, 1'b0, word, short_first);
    for (int i = 1; i < len; i++) begin
      if (i <= nbits) b = word[SAMPLE_W - i];
      else            b = (i % 2 == 1);
      send_bit(wsv, b, full_left && (i == SAMPLE_W), word, 1'b0);
      last_sd = b;
    end
  endtask

  task automatic send_frame(input logic [SAMPLE_W-1:0] left, input logic [SAMPLE_W-1:0] right);
    send_slot(1'b0, left,  SAMPLE_W, SLOT_LEN, 1'b1, 1'b0);
    send_slot(1'b1, right, SAMPLE_W, SLOT_LEN, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_mic",       32'(mic),       32'd0);
    check("mid_rst_mic_valid", 32'(mic_valid), 32'd0);
    check("mid_rst_overrun",   32'(overrun),   32'd0);
    check("mid_rst_frame_err", 32'(frame_err), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sck = 1'b0; ws = 1'b1; sd = 1'b0; mic_ready = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("reset_mic",       32'(mic),       32'd0);
    check("reset_mic_valid", 32'(mic_valid), 32'd0);
    check("reset_overrun",   32'(overrun),   32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Standard frame with a short right-slot lead-in
    send_slot(1'b1, '0, 0, 8, 1'b0, 1'b0);
    mic_ready = 1'b1;
    valid_cnt = 0;
    send_frame(24'hA5C3F1, 24'h123456);
    check("std_pulse_len", 32'(valid_cnt),      32'd1);
    check("std_word",      32'(last_valid_mic), 32'h00A5C3F1);

    // Backpressure across two frames
    mic_ready = 1'b0;
    send_frame(24'h000001, 24'h654321);
    send_frame(24'h7FFFFF, 24'h0F00F0);
    check("bp_mic",     32'(mic),       32'h00000001);
    check("bp_valid",   32'(mic_valid), 32'd1);
    check("bp_overrun", 32'(overrun),   32'd1);

    // Ready pulse on the exact completion cycle of the next word
    pulse_reset();
    send_slot(1'b1, '0, 0, 8, 1'b0, 1'b0);
    send_frame(24'h3C3C3C, 24'h111111);
    pulse_armed = 1'b1;
    send_frame(24'h800000, 24'h222222);
    check("sim_mic",     32'(mic),       32'h00800000);
    check("sim_valid",   32'(mic_valid), 32'd1);
    check("sim_overrun", 32'(overrun),   32'd0);
    mic_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("sim_drained", 32'(mic_valid), 32'd0);

    // Short left slot, then a good frame
    valid_cnt = 0;
    send_slot(1'b0, 24'hABCDEF, 16, 17, 1'b0, 1'b0);
    send_slot(1'b1, 24'h123456, SAMPLE_W, SLOT_LEN, 1'b0, 1'b1);
    check("short_ferr",  32'(frame_err), 32'd1);
    check("short_valid", 32'(valid_cnt), 32'd0);
    send_frame(24'h0F0F0F, 24'h333333);
    check("after_short_word", 32'(last_valid_mic), 32'h000F0F0F);
    check("after_short_cnt",  32'(valid_cnt),      32'd1);

    // Reset after 10 left bits; the rest of that slot must be ignored
    send_slot(1'b0, 24'hABCDEF, 10, 11, 1'b0, 1'b0);
    pulse_reset();
    valid_cnt = 0;
    send_slot(1'b0, 24'h5A5A5A, SAMPLE_W, SLOT_LEN - 11, 1'b0, 1'b0);
    send_slot(1'b1, 24'h444444, SAMPLE_W, SLOT_LEN, 1'b0, 1'b0);
    check("rst_remainder_cnt",  32'(valid_cnt), 32'd0);
    check("rst_remainder_ferr", 32'(frame_err), 32'd0);
    send_frame(24'hFFFFFF, 24'h555555);
    check("after_rst_word", 32'(last_valid_mic), 32'h00FFFFFF);
    check("after_rst_cnt",  32'(valid_cnt),      32'd1);

    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
